ts_word_packer: RTL and testbench
=================================

Name: ts_word_packer

Overview:
- Parametrised packer: concatenates PACK_CNT input words of IN_W bits into one OUT_W-bit word for the TS capture path.
- Replaces the fixed 10-into-32 shift/load scheme with a valid/ready handshake on both sides and backpressure.
- Adds an explicit flush for partial words and a valid-word count on output.
- Sits between the TS byte/symbol front end and the wide storage write path.

Parameters:
- IN_W, 10, input word width in bits.
- OUT_W, 32, output word width in bits. Legal only if IN_W*PACK_CNT <= OUT_W; the design must fail elaboration otherwise.
- PACK_CNT, 3, number of input words per full output word, >= 2.
- CW, $clog2(PACK_CNT+1), width of the count fields (derived, not overridable).

Ports:
- CLOCK  in  1  sole clock, rising edge.
- RESET  in  1  synchronous, active-high reset.
- DATA_IN  in  IN_W  input word.
- IN_VALID  in  1  DATA_IN valid.
- IN_READY  out  1  packer can accept DATA_IN.
- FLUSH  in  1  single-cycle request to emit the current partial word.
- DATA_OUT  out  OUT_W  packed word.
- OUT_VALID  out  1  DATA_OUT valid.
- OUT_READY  in  1  downstream accepts DATA_OUT.
- OUT_CNT  out  CW  number of valid input words in DATA_OUT (1..PACK_CNT).
- OUT_PARITY  out  1  see Optional Feature.

Behaviour:
- Clocking: one clock, CLOCK. RESET is synchronous and active-high.
- Internal state:
  - SHREG[OUT_W-1:0], fill register.
  - CNT[CW-1:0], words held, range 0..PACK_CNT.
  - FLUSH_PEND, 1 bit.
  - Output register holding DATA_OUT, OUT_CNT, OUT_PARITY, OUT_VALID.
- RESET (any cycle, including mid-word): SHREG=0, CNT=0, FLUSH_PEND=0, DATA_OUT=0, OUT_CNT=0, OUT_VALID=0, OUT_PARITY=0. Partial and held data are discarded.
- IN_READY = (CNT < PACK_CNT) && !FLUSH_PEND. It is combinational from registers only, never from IN_VALID.
- Accept when IN_VALID && IN_READY: SHREG <= (SHREG << IN_W) | DATA_IN, zero-extended; CNT <= CNT+1.
- Layout: first accepted word lands in bits [IN_W*PACK_CNT-1 -: IN_W]; last word in [IN_W-1:0]; bits above IN_W*PACK_CNT are always 0.
- FLUSH sets FLUSH_PEND. If FLUSH coincides with an accept, the accepted word is included before the flush.
- Slot free = !OUT_VALID || OUT_READY.
- Transfer condition: slot free && (CNT==PACK_CNT || (FLUSH_PEND && CNT>0)). On transfer:
  - DATA_OUT <= SHREG << (IN_W*(PACK_CNT-CNT)), so partial words are left-aligned and zero-padded.
  - OUT_CNT <= CNT; OUT_VALID <= 1.
  - SHREG <= 0, CNT <= 0, FLUSH_PEND <= 0.
- No transfer and output handshake completes (OUT_VALID && OUT_READY): OUT_VALID <= 0. DATA_OUT and OUT_CNT hold their last value.
- FLUSH_PEND with CNT==0: cleared on the next edge, no output generated, no empty word.
- FLUSH while FLUSH_PEND is already set: no additional effect.
- Latency: the last word accepted at edge t gives OUT_VALID=1 after edge t+1.
- Throughput: at most PACK_CNT input words per PACK_CNT+1 cycles. The one-cycle bubble is intended.
- Backpressure: while OUT_VALID && !OUT_READY, DATA_OUT, OUT_CNT and OUT_PARITY are stable. Fill continues until CNT==PACK_CNT, then IN_READY=0.
- No data loss or duplication under any IN_VALID / OUT_READY / FLUSH pattern.

Optional Feature:
- Macro: TS_PACKER_PARITY_EN.
- Defined: OUT_PARITY is registered with DATA_OUT on transfer and equals the XOR reduction of the DATA_OUT value being loaded (1 if DATA_OUT has an odd number of ones).
- Undefined: OUT_PARITY is constant 0, and no parity logic is synthesised.
- The port exists in both builds.

Test Plan (IN_W=10, OUT_W=32, PACK_CNT=3):
- Full word: RESET, then accept 0x3FF, 0x001, 0x155 back-to-back with OUT_READY=1 -> DATA_OUT=0x3FF00555, OUT_CNT=3, OUT_VALID high one cycle, appearing one cycle after the third accept; OUT_PARITY=0 with TS_PACKER_PARITY_EN.
- Flush partial: accept 0x2AA, 0x0F0, then pulse FLUSH -> DATA_OUT=0x2AA3C000, OUT_CNT=2; OUT_PARITY=1 with macro, 0 without.
- Simultaneous: FLUSH in the same cycle as accepting 0x011 with CNT=0 -> DATA_OUT=0x01100000, OUT_CNT=1; IN_READY low until the transfer.
- Backpressure: OUT_READY=0, two full words of input -> first word held stable; second fills to CNT=3; IN_READY=0. Raise OUT_READY -> first word consumed, second emitted next cycle, intact and in order.
- Empty flush, then RESET: FLUSH with CNT=0 -> no OUT_VALID. Accept 2 words, assert RESET for 1 cycle -> all outputs 0, IN_READY=1; no stale word emitted after reset.

Source files
------------

// File: rtl/ts_word_packer.sv
// ts_word_packer
// Packs PACK_CNT input words of IN_W bits into one OUT_W-bit output word.
// Both sides use a valid/ready handshake. FLUSH emits a partial word,
// left-aligned and zero-padded. OUT_CNT reports how many input words the
// output word holds.
// Optional build macro: TS_PACKER_PARITY_EN. When it is defined, OUT_PARITY
// carries the XOR reduction of DATA_OUT. When it is not defined, OUT_PARITY
// is tied to 0.
module ts_word_packer #(
    parameter int IN_W     = 10,
    parameter int OUT_W    = 32,
    parameter int PACK_CNT = 3,
    localparam int CW      = $clog2(PACK_CNT + 1)
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic [IN_W-1:0]  DATA_IN,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic             FLUSH,
    output logic [OUT_W-1:0] DATA_OUT,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [CW-1:0]    OUT_CNT,
    output logic             OUT_PARITY
);

    // A packed word must fit in the output. At least two words per output.
    if ((IN_W * PACK_CNT > OUT_W) || (PACK_CNT < 2)) begin : g_bad_params
        $error("ts_word_packer: illegal parameters IN_W*PACK_CNT must be <= OUT_W and PACK_CNT >= 2");
    end

    logic [OUT_W-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic             flush_pend;

    logic             accept;
    logic             slot_free;
    logic             cnt_full;
    logic             transfer;
    logic [OUT_W-1:0] aligned_word;

    // Handshake and transfer decisions. IN_READY depends only on registers.
    always_comb begin
        cnt_full  = (cnt == CW'(PACK_CNT));
        IN_READY  = !cnt_full && !flush_pend;
        accept    = IN_VALID && IN_READY;
        slot_free = !OUT_VALID || OUT_READY;
        transfer  = slot_free && (cnt_full || (flush_pend && (cnt != '0)));
    end

    // Left-align a partial word by shifting past the slots it never filled.
    always_comb begin
        aligned_word = shreg << (IN_W * (PACK_CNT - int'(cnt)));
    end

    // Fill register. It shifts in accepted words and empties on transfer.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (transfer) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (accept) begin
            shreg <= (shreg << IN_W) | OUT_W'(DATA_IN);
            cnt   <= cnt + CW'(1);
        end
    end

    // Pending flush. It clears once the word has left, or at once if nothing is held.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            flush_pend <= 1'b0;
        end else if (flush_pend) begin
            if (transfer || (cnt == '0)) begin
                flush_pend <= 1'b0;
            end
        end else if (FLUSH) begin
            flush_pend <= 1'b1;
        end
    end

    // Output register. It loads on transfer and drops valid after a bare handshake.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            DATA_OUT  <= '0;
            OUT_CNT   <= '0;
            OUT_VALID <= 1'b0;
        end else if (transfer) begin
            DATA_OUT  <= aligned_word;
            OUT_CNT   <= cnt;
            OUT_VALID <= 1'b1;
        end else if (OUT_VALID && OUT_READY) begin
            OUT_VALID <= 1'b0;
        end
    end

`ifdef TS_PACKER_PARITY_EN
    logic out_parity_r;

    // Parity is registered together with the data word it describes.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            out_parity_r <= 1'b0;
        end else if (transfer) begin
            out_parity_r <= ^aligned_word;
        end
    end

    assign OUT_PARITY = out_parity_r;
`else
    assign OUT_PARITY = 1'b0;
`endif

endmodule

// File: tb/tb_ts_word_packer.sv
// Testbench for ts_word_packer with IN_W=10, OUT_W=32, PACK_CNT=3.
// It runs directed table vectors, hand-written corner sequences, and a
// randomized run checked against a word-group reference model.
module tb_ts_word_packer;

    localparam int IN_W     = 10;
    localparam int OUT_W    = 32;
    localparam int PACK_CNT = 3;
    localparam int CW       = $clog2(PACK_CNT + 1);

    logic             CLOCK = 1'b0;
    logic             RESET = 1'b0;
    logic [IN_W-1:0]  DATA_IN = '0;
    logic             IN_VALID = 1'b0;
    logic             IN_READY;
    logic             FLUSH = 1'b0;
    logic [OUT_W-1:0] DATA_OUT;
    logic             OUT_VALID;
    logic             OUT_READY = 1'b0;
    logic [CW-1:0]    OUT_CNT;
    logic             OUT_PARITY;

    ts_word_packer #(.IN_W(IN_W), .OUT_W(OUT_W), .PACK_CNT(PACK_CNT)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .DATA_IN(DATA_IN), .IN_VALID(IN_VALID),
        .IN_READY(IN_READY), .FLUSH(FLUSH), .DATA_OUT(DATA_OUT),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_CNT(OUT_CNT),
        .OUT_PARITY(OUT_PARITY)
    );

    always #5 CLOCK = ~CLOCK;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        int                   n;
        int                   mode;      // 0 full, 1 flush with last word, 2 flush afterwards
        logic [0:2][IN_W-1:0] w;
        logic [OUT_W-1:0]     exp_data;
        logic [CW-1:0]        exp_cnt;
        logic                 exp_par;   // parity value when the parity build is used
    } vec_t;

    typedef struct {
        logic [OUT_W-1:0] data;
        logic [CW-1:0]    cnt;
    } exp_t;

    exp_t             exp_q[$];
    logic [IN_W-1:0]  open_q[$];
    logic             hold_valid = 1'b0;
    logic [OUT_W-1:0] held_data  = '0;
    logic [CW-1:0]    held_cnt   = '0;

    function automatic logic par_req(input logic p);
`ifdef TS_PACKER_PARITY_EN
        return p;
`else
        return 1'b0 & p;
`endif
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic reset_dut();
        IN_VALID = 1'b0;
        FLUSH    = 1'b0;
        RESET    = 1'b1;
        step();
        RESET    = 1'b0;
    endtask

    // Wait (bounded) for IN_READY, then present one word for one cycle
    task automatic apply_stimulus(input logic [IN_W-1:0] w, input logic fl);
        int waited = 0;
        while (!IN_READY && waited < 20) begin
            step();
            waited++;
        end
        if (!IN_READY) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL push_wait: IN_READY=0 after %0d cycles, required 1", waited);
            return;
        end
        DATA_IN  = w;
        IN_VALID = 1'b1;
        FLUSH    = fl;
        step();
        IN_VALID = 1'b0;
        FLUSH    = 1'b0;
    endtask

    task automatic pulse_flush();
        FLUSH = 1'b1;
        step();
        FLUSH = 1'b0;
    endtask

    task automatic wait_valid(input string name, input int exp_lat);
        int lat = 0;
        while (!OUT_VALID && lat < 10) begin
            step();
            lat++;
        end
        check_output({name, "_latency"}, lat, exp_lat);
    endtask

    // Reference model: close the open group into an expected output word
    task automatic close_group();
        exp_t e;
        e.data = '0;
        for (int i = 0; i < open_q.size(); i++) begin
            e.data = e.data | (OUT_W'(open_q[i]) << (IN_W * (PACK_CNT - 1 - i)));
        end
        e.cnt = CW'(open_q.size());
        exp_q.push_back(e);
        open_q.delete();
    endtask

    task automatic random_cycle(input bit allow_in, input bit fl);
        logic acc;
        logic ohs;
        exp_t e;
        DATA_IN   = IN_W'($urandom);
        IN_VALID  = allow_in && ($urandom_range(0, 9) < 7);
        OUT_READY = !allow_in || ($urandom_range(0, 9) < 6);
        FLUSH     = fl;
        acc = IN_VALID && IN_READY;
        ohs = OUT_VALID && OUT_READY;
        if (hold_valid) begin
            check_output("hold_valid", OUT_VALID, 1);
            check_output("hold_data", DATA_OUT, held_data);
            check_output("hold_cnt", OUT_CNT, held_cnt);
        end
        hold_valid = OUT_VALID && !OUT_READY;
        held_data  = DATA_OUT;
        held_cnt   = OUT_CNT;
        if (ohs) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL rand_unexpected: got word 0x%0h, required no output", DATA_OUT);
            end else begin
                e = exp_q.pop_front();
                check_output("rand_data", DATA_OUT, e.data);
                check_output("rand_cnt", OUT_CNT, e.cnt);
                check_output("rand_parity", OUT_PARITY, par_req(^e.data));
            end
        end
        if (acc) begin
            open_q.push_back(DATA_IN);
            if (open_q.size() == PACK_CNT) close_group();
        end
        if (FLUSH && open_q.size() > 0) close_group();
        step();
        FLUSH    = 1'b0;
        IN_VALID = 1'b0;
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t vecs[8];
        int   seen;

        vecs[0] = '{3, 0, {10'h3FF, 10'h001, 10'h155}, 32'h3FF00555, 2'd3, 1'b0};
        vecs[1] = '{2, 2, {10'h2AA, 10'h0F0, 10'h000}, 32'h2AA3C000, 2'd2, 1'b1};
        vecs[2] = '{1, 1, {10'h011, 10'h000, 10'h000}, 32'h01100000, 2'd1, 1'b0};
        vecs[3] = '{3, 0, {10'h000, 10'h000, 10'h000}, 32'h00000000, 2'd3, 1'b0};
        vecs[4] = '{3, 0, {10'h3FF, 10'h3FF, 10'h3FF}, 32'h3FFFFFFF, 2'd3, 1'b0};
        vecs[5] = '{1, 2, {10'h001, 10'h000, 10'h000}, 32'h00100000, 2'd1, 1'b1};
        vecs[6] = '{2, 1, {10'h123, 10'h045, 10'h000}, 32'h12311400, 2'd2, 1'b1};
        vecs[7] = '{3, 1, {10'h155, 10'h2AA, 10'h0FF}, 32'h155AA8FF, 2'd3, 1'b0};

        // Reset state
        reset_dut();
        check_output("rst_data", DATA_OUT, 0);
        check_output("rst_cnt", OUT_CNT, 0);
        check_output("rst_valid", OUT_VALID, 0);
        check_output("rst_parity", OUT_PARITY, 0);
        check_output("rst_in_ready", IN_READY, 1);

        // Table-driven vectors
        OUT_READY = 1'b1;
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < vecs[i].n; k++) begin
                apply_stimulus(vecs[i].w[k], (vecs[i].mode == 1) && (k == vecs[i].n - 1));
            end
            check_output($sformatf("vec%0d_early_valid", i), OUT_VALID, 0);
            if (vecs[i].mode == 2) pulse_flush();
            wait_valid($sformatf("vec%0d", i), 1);
            check_output($sformatf("vec%0d_data", i), DATA_OUT, vecs[i].exp_data);
            check_output($sformatf("vec%0d_cnt", i), OUT_CNT, vecs[i].exp_cnt);
            check_output($sformatf("vec%0d_parity", i), OUT_PARITY, par_req(vecs[i].exp_par));
            step();
            check_output($sformatf("vec%0d_valid_drop", i), OUT_VALID, 0);
            step();
        end

        // Simultaneous flush and accept: IN_READY low until the transfer
        apply_stimulus(10'h077, 1'b1);
        check_output("sim_in_ready_low", IN_READY, 0);
        check_output("sim_valid_low", OUT_VALID, 0);
        step();
        check_output("sim_valid", OUT_VALID, 1);
        check_output("sim_data", DATA_OUT, 32'h07700000);
        check_output("sim_cnt", OUT_CNT, 1);
        check_output("sim_in_ready_back", IN_READY, 1);
        step();

        // Backpressure: two full words while downstream stalls
        OUT_READY = 1'b0;
        apply_stimulus(10'h111, 1'b0);
        apply_stimulus(10'h222, 1'b0);
        apply_stimulus(10'h333, 1'b0);
        apply_stimulus(10'h0AB, 1'b0);
        apply_stimulus(10'h0CD, 1'b0);
        apply_stimulus(10'h0EF, 1'b0);
        step();
        step();
        check_output("bp_valid", OUT_VALID, 1);
        check_output("bp_first_data", DATA_OUT, 32'h11188B33);
        check_output("bp_first_cnt", OUT_CNT, 3);
        check_output("bp_in_ready", IN_READY, 0);
        OUT_READY = 1'b1;
        step();
        check_output("bp_second_valid", OUT_VALID, 1);
        check_output("bp_second_data", DATA_OUT, 32'h0AB334EF);
        check_output("bp_second_cnt", OUT_CNT, 3);
        step();
        check_output("bp_drained", OUT_VALID, 0);

        // Empty flush: no word produced
        pulse_flush();
        check_output("eflush_in_ready_low", IN_READY, 0);
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            if (OUT_VALID) seen++;
            step();
        end
        check_output("eflush_no_output", seen, 0);
        check_output("eflush_in_ready_back", IN_READY, 1);

        // Reset mid-word discards partial data
        apply_stimulus(10'h100, 1'b0);
        apply_stimulus(10'h200, 1'b0);
        reset_dut();
        check_output("mrst_data", DATA_OUT, 0);
        check_output("mrst_cnt", OUT_CNT, 0);
        check_output("mrst_valid", OUT_VALID, 0);
        check_output("mrst_parity", OUT_PARITY, 0);
        check_output("mrst_in_ready", IN_READY, 1);
        pulse_flush();
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            if (OUT_VALID) seen++;
            step();
        end
        check_output("mrst_no_stale", seen, 0);

        // Randomized run against the reference model
        reset_dut();
        exp_q.delete();
        open_q.delete();
        hold_valid = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            random_cycle(1'b1, ($urandom_range(0, 15) == 0));
        end
        random_cycle(1'b0, 1'b1);
        for (int c = 0; c < 20; c++) begin
            random_cycle(1'b0, 1'b0);
        end
        check_output("rand_exp_drained", exp_q.size(), 0);
        check_output("rand_open_empty", open_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
